// File: rtl/adder_arbiter.sv
// Two-requester round-robin adder with a single registered result slot.
// Define ADDER_ARBITER_SAT_EN to saturate res_sum to all-ones on carry-out.
module adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    output logic [7:0]       op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             ptr_q;
    logic             slot_free;
    logic             win0;
    logic             win1;
    logic             accept;
    logic             sel_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   full_sum;
    logic [WIDTH-1:0] new_sum;
    logic             consume;

    assign slot_free = (state_q == EMPTY) || res_ready;

    // Under contention the requester that did not win last time goes first.
    assign win0 = req0_valid && (!req1_valid || ptr_q);
    assign win1 = req1_valid && (!req0_valid || !ptr_q);

    assign req0_ready = !rst && slot_free && win0;
    assign req1_ready = !rst && slot_free && win1;
    assign accept     = req0_ready || req1_ready;

    assign sel_id   = req1_ready;
    assign sel_a    = sel_id ? req1_a : req0_a;
    assign sel_b    = sel_id ? req1_b : req0_b;
    assign full_sum = {1'b0, sel_a} + {1'b0, sel_b};

`ifdef ADDER_ARBITER_SAT_EN
    assign new_sum = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
`else
    assign new_sum = full_sum[WIDTH-1:0];
`endif

    assign res_valid = (state_q == FULL);
    assign consume   = res_valid && res_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept)         state_d = FULL;
                else if (res_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            ptr_q     <= 1'b1;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q     <= sel_id;
                res_sum   <= new_sum;
                res_carry <= full_sum[WIDTH];
                res_id    <= sel_id;
            end
            if (consume) op_count <= op_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter against a
// transaction-level model of the result slot, grant pointer and counter.
module tb_adder_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       req1_ready;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_sum;
    logic       res_carry;
    logic       res_id;
    logic [7:0] op_count;

    int errors = 0;
    int checks = 0;

    // model state
    bit       m_valid;
    bit [7:0] m_sum;
    bit       m_carry;
    bit       m_id;
    bit       m_ptr;
    int       m_cnt;

    adder_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (rst) return -1;
        if (m_valid && !res_ready) return -1;
        if (req0_valid && req1_valid) return m_ptr ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0;
        m_ptr = 1; m_cnt = 0;
    endtask

    // advance one clock, updating the model with the inputs seen at the edge
    task automatic tick();
        int g;
        int a;
        int b;
        int s;
        g = exp_grant();
        if (rst) model_reset();
        else begin
            if (m_valid && res_ready) m_cnt = (m_cnt + 1) % 256;
            if (g >= 0) begin
                a = (g == 1) ? int'(req1_a) : int'(req0_a);
                b = (g == 1) ? int'(req1_b) : int'(req0_b);
                s = a + b;
                m_carry = (s > 255);
`ifdef ADDER_ARBITER_SAT_EN
                m_sum = m_carry ? 8'hFF : 8'(s % 256);
`else
                m_sum = 8'(s % 256);
`endif
                m_id = (g == 1);
                m_ptr = (g == 1);
                m_valid = 1;
            end else if (res_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        res_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tick();
        model_reset();
        checks++;
        if (res_valid !== 1'b0 || res_sum !== 8'h00 || res_carry !== 1'b0 ||
            res_id !== 1'b0 || op_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: v=%b s=%h c=%b id=%b cnt=%0d want all zero",
                     res_valid, res_sum, res_carry, res_id, op_count);
        end
        rst = 0;
        idle_inputs();
        #1;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1; req0_a = 8'h12; req0_b = 8'h34; res_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 8'h46 || res_carry !== 1'b0 || res_id !== 1'b0) begin
            errors++;
            $display("FAIL single_result: v=%b s=%h c=%b id=%b want 1 46 0 0",
                     res_valid, res_sum, res_carry, res_id);
        end
        tick();
        checks++;
        if (op_count !== 8'd1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_count: cnt=%0d v=%b want 1 0", op_count, res_valid);
        end
    endtask

    task automatic test_contention();
        do_reset();
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        for (int i = 0; i < 6; i++) begin
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            #1;
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %b%b", i, req0_ready, req1_ready);
            end
            if (i > 0) begin
                checks++;
                if (res_valid !== 1'b1 || res_id !== ((i - 1) % 2 == 1) ||
                    res_sum !== m_sum || res_carry !== m_carry) begin
                    errors++;
                    $display("FAIL contention_result[%0d]: v=%b id=%b s=%h c=%b want id=%0d s=%h c=%b",
                             i, res_valid, res_id, res_sum, res_carry, (i - 1) % 2, m_sum, m_carry);
                end
            end
            tick();
        end
        idle_inputs();
        res_ready = 1;
        tick();
    endtask

    task automatic test_overflow();
        req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h20; res_ready = 1;
        tick();
        req1_valid = 0;
        #1;
        checks++;
`ifdef ADDER_ARBITER_SAT_EN
        if (res_valid !== 1'b1 || res_carry !== 1'b1 || res_sum !== 8'hFF || res_id !== 1'b1) begin
`else
        if (res_valid !== 1'b1 || res_carry !== 1'b1 || res_sum !== 8'h10 || res_id !== 1'b1) begin
`endif
            errors++;
            $display("FAIL overflow: v=%b s=%h c=%b id=%b", res_valid, res_sum, res_carry, res_id);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cnt0;
        idle_inputs();
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; res_ready = 1;
        tick();
        req0_a = 8'h03; req0_b = 8'h04; res_ready = 0;
        cnt0 = int'(op_count);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_sum !== 8'h03 || res_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || int'(op_count) != cnt0) begin
                errors++;
                $display("FAIL backpressure[%0d]: v=%b s=%h id=%b rdy=%b%b cnt=%0d",
                         i, res_valid, res_sum, res_id, req0_ready, req1_ready, op_count);
            end
            tick();
        end
        res_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_accept: req0_ready=%b want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 8'h07 || int'(op_count) != (cnt0 + 1) % 256) begin
            errors++;
            $display("FAIL drain_result: v=%b s=%h cnt=%0d want 1 07 %0d",
                     res_valid, res_sum, op_count, (cnt0 + 1) % 256);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req0_valid = 1; res_ready = 1;
        for (int i = 0; i < 256; i++) begin
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            tick();
        end
        checks++;
        if (op_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: cnt=%0d want 255", op_count);
        end
        tick();
        checks++;
        if (op_count !== 8'd0 || m_cnt != 0) begin
            errors++;
            $display("FAIL wrap_0: cnt=%0d want 0", op_count);
        end
        idle_inputs();
        res_ready = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        req1_valid = 1; req1_a = 8'h55; req1_b = 8'h11;
        tick();
        req1_valid = 0; req0_valid = 1;
        #1;
        rst = 1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || op_count !== 8'd0 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: v=%b cnt=%0d rdy0=%b want 0 0 0",
                     res_valid, op_count, req0_ready);
        end
        model_reset();
        tick();
        rst = 0;
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_grant: got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        idle_inputs();
        res_ready = 1;
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = exp_grant();
            checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1) ||
                res_valid !== m_valid || int'(op_count) != m_cnt ||
                (m_valid && (res_sum !== m_sum || res_carry !== m_carry || res_id !== m_id))) begin
                errors++;
                $display("FAIL random[%0d]: rdy=%b%b v=%b s=%h c=%b id=%b cnt=%0d want g=%0d v=%b s=%h c=%b id=%b cnt=%0d",
                         i, req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id, op_count,
                         g, m_valid, m_sum, m_carry, m_id, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        model_reset();
        #2;
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
